// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - execute-to-writeback result handshake bundle
interface wb_regfile_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic          w_enable;
  logic          w_select;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_id;
  logic [2:0]    dest_reg;
  logic          set_flags;
  logic [3:0]    flags_in;

  modport master (
    output in_valid, w_enable, w_select, w_alu, w_id, dest_reg, set_flags, flags_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, w_enable, w_select, w_alu, w_id, dest_reg, set_flags, flags_in,
    output in_ready
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: staging register, 8x32 regfile, CPSR, branch condition; optional WB_BYPASS_EN forwards staged data
module wb_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    wb,
  input  logic           hold,
  input  logic [2:0]     rd_addr_0,
  input  logic [2:0]     rd_addr_1,
  output logic [DW-1:0]  r_val_0,
  output logic [DW-1:0]  r_val_1,
  output logic [3:0]     flags,
  input  logic [3:0]     B_cond,
  output logic           cond_pass,
  output logic [31:0]    retire_count
);

  logic [DW-1:0] regs [NREGS];
  logic [3:0]    cpsr;

  logic          stg_valid;
  logic          stg_we;
  logic [2:0]    stg_dest;
  logic [DW-1:0] stg_data;
  logic          stg_sf;
  logic [3:0]    stg_flags;

  logic accept;
  logic commit;

  assign wb.in_ready = !stg_valid || !hold;
  assign accept      = wb.in_valid && wb.in_ready;
  assign commit      = stg_valid && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cpsr         <= 4'b0000;
      retire_count <= 32'd0;
      stg_valid    <= 1'b0;
      stg_we       <= 1'b0;
      stg_dest     <= 3'd0;
      stg_data     <= '0;
      stg_sf       <= 1'b0;
      stg_flags    <= 4'b0000;
    end else begin
      if (commit) begin
        if (stg_we) regs[stg_dest] <= stg_data;
        if (stg_sf) cpsr <= stg_flags;
        retire_count <= retire_count + 32'd1;
      end
      // A same-cycle accept overrides the clear, keeping the pipe full.
      if (accept) begin
        stg_valid <= 1'b1;
        stg_we    <= wb.w_enable;
        stg_dest  <= wb.dest_reg;
        stg_data  <= wb.w_select ? wb.w_id : wb.w_alu;
        stg_sf    <= wb.set_flags;
        stg_flags <= wb.flags_in;
      end else if (commit) begin
        stg_valid <= 1'b0;
      end
    end
  end

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, c, z, v;
    logic res;
    {n, c, z, v} = f;
    case (code)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c && !z;
      4'b1001: res = !(c && !z);
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z && (n == v);
      4'b1101: res = z || (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  always_comb begin
    r_val_0 = regs[rd_addr_0];
    r_val_1 = regs[rd_addr_1];
    flags   = cpsr;
`ifdef WB_BYPASS_EN
    if (stg_valid && stg_we && stg_dest == rd_addr_0) r_val_0 = stg_data;
    if (stg_valid && stg_we && stg_dest == rd_addr_1) r_val_1 = stg_data;
    if (stg_valid && stg_sf) flags = stg_flags;
`endif
    cond_pass = cond_eval(B_cond, flags);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [2:0]  rd_addr_0;
  logic [2:0]  rd_addr_1;
  logic [31:0] r_val_0;
  logic [31:0] r_val_1;
  logic [3:0]  flags;
  logic [3:0]  B_cond;
  logic        cond_pass;
  logic [31:0] retire_count;

  int tests = 0;
  int fails = 0;

  wb_regfile_if #(.DW(32)) wb ();

  wb_regfile #(.NREGS(8), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb),
    .hold         (hold),
    .rd_addr_0    (rd_addr_0),
    .rd_addr_1    (rd_addr_1),
    .r_val_0      (r_val_0),
    .r_val_1      (r_val_1),
    .flags        (flags),
    .B_cond       (B_cond),
    .cond_pass    (cond_pass),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic we, input logic sel, input logic [31:0] alu,
                         input logic [31:0] id, input logic [2:0] dst,
                         input logic sf, input logic [3:0] fin);
    wb.in_valid  = 1'b1;
    wb.w_enable  = we;
    wb.w_select  = sel;
    wb.w_alu     = alu;
    wb.w_id      = id;
    wb.dest_reg  = dst;
    wb.set_flags = sf;
    wb.flags_in  = fin;
  endtask

  logic [31:0] pre_r2;
  logic [31:0] held_r4;

  initial begin
`ifdef WB_BYPASS_EN
    pre_r2  = 32'h0000_00AA;
    held_r4 = 32'h0000_0055;
`else
    pre_r2  = 32'h0000_0000;
    held_r4 = 32'h0000_0000;
`endif
    rst = 1'b1;
    hold = 1'b0;
    rd_addr_0 = 3'd0;
    rd_addr_1 = 3'd0;
    B_cond = 4'b0000;
    present(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 4'h0);
    wb.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_in_ready", {31'b0, wb.in_ready}, 32'd1);
    check("reset_r_val_0", r_val_0, 32'h0);
    check("reset_r_val_1", r_val_1, 32'h0);
    check("reset_flags", {28'b0, flags}, 32'h0);
    check("reset_cond_pass_eq", {31'b0, cond_pass}, 32'd0);
    check("reset_retire", retire_count, 32'd0);

    // ALU path write to r3
    present(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 3'd3, 1'b0, 4'h0);
    tick();
    wb.in_valid = 1'b0;
    rd_addr_0 = 3'd3;
    tick();
    check("alu_write_r3", r_val_0, 32'h0000_1234);
    check("alu_write_retire", retire_count, 32'd1);

    // decode path write to r7
    present(1'b1, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 3'd7, 1'b0, 4'h0);
    tick();
    wb.in_valid = 1'b0;
    rd_addr_1 = 3'd7;
    tick();
    check("id_write_r7", r_val_1, 32'hDEAD_BEEF);
    check("id_write_retire", retire_count, 32'd2);

    // flags C only, no register write
    present(1'b0, 1'b0, 32'h0000_0099, 32'h0, 3'd3, 1'b1, 4'b0100);
    tick();
    wb.in_valid = 1'b0;
    tick();
    check("flags_c", {28'b0, flags}, 32'h4);
    check("r3_untouched_by_flag_op", r_val_0, 32'h0000_1234);
    B_cond = 4'b1000; #1;
    check("hi_c_only", {31'b0, cond_pass}, 32'd1);
    B_cond = 4'b0011; #1;
    check("cc_c_set", {31'b0, cond_pass}, 32'd0);

    // flags C and Z
    present(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 4'b0110);
    tick();
    wb.in_valid = 1'b0;
    tick();
    check("flags_cz", {28'b0, flags}, 32'h6);
    B_cond = 4'b1000; #1;
    check("hi_cz", {31'b0, cond_pass}, 32'd0);
    B_cond = 4'b1001; #1;
    check("ls_cz", {31'b0, cond_pass}, 32'd1);
    B_cond = 4'b1111; #1;
    check("nop_never", {31'b0, cond_pass}, 32'd0);
    B_cond = 4'b1110; #1;
    check("al_always", {31'b0, cond_pass}, 32'd1);
    B_cond = 4'b1100; #1;
    check("gt_z_set", {31'b0, cond_pass}, 32'd0);
    check("retire_after_flags", retire_count, 32'd4);

    // hold: stage r4 while hold is high, then offer r6 which must wait
    hold = 1'b1;
    rd_addr_0 = 3'd4;
    rd_addr_1 = 3'd6;
    present(1'b1, 1'b0, 32'h0000_0055, 32'h0, 3'd4, 1'b0, 4'h0);
    tick();
    present(1'b1, 1'b0, 32'h0000_0066, 32'h0, 3'd6, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready_low", {31'b0, wb.in_ready}, 32'd0);
      check("hold_r4_value", r_val_0, held_r4);
      tick();
    end
    check("hold_retire_frozen", retire_count, 32'd4);
    hold = 1'b0; #1;
    check("unhold_in_ready", {31'b0, wb.in_ready}, 32'd1);
    tick();
    wb.in_valid = 1'b0;
    check("unhold_commit_r4", r_val_0, 32'h0000_0055);
    check("unhold_retire", retire_count, 32'd5);
    tick();
    check("queued_r6", r_val_1, 32'h0000_0066);
    check("queued_retire", retire_count, 32'd6);

    // back-to-back writes to r1
    rd_addr_0 = 3'd1;
    present(1'b1, 1'b0, 32'h0000_0001, 32'h0, 3'd1, 1'b0, 4'h0);
    tick();
    present(1'b1, 1'b0, 32'h0000_0002, 32'h0, 3'd1, 1'b0, 4'h0);
    tick();
    wb.in_valid = 1'b0;
    check("b2b_mid_retire", retire_count, 32'd7);
    tick();
    check("b2b_r1", r_val_0, 32'h0000_0002);
    check("b2b_retire", retire_count, 32'd8);

    // read r2 one cycle after accept: bypass-dependent
    rd_addr_0 = 3'd2;
    rd_addr_1 = 3'd2;
    present(1'b1, 1'b0, 32'h0000_00AA, 32'h0, 3'd2, 1'b0, 4'h0);
    tick();
    wb.in_valid = 1'b0;
    check("r2_before_commit", r_val_0, pre_r2);
    tick();
    check("r2_port0", r_val_0, 32'h0000_00AA);
    check("r2_port1_same", r_val_1, 32'h0000_00AA);

    // reset while an entry is staged discards it
    rd_addr_0 = 3'd5;
    rd_addr_1 = 3'd3;
    present(1'b1, 1'b0, 32'h0000_0077, 32'h0, 3'd5, 1'b1, 4'b1111);
    tick();
    wb.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_r5_discarded", r_val_0, 32'h0);
    check("rst_r3_cleared", r_val_1, 32'h0);
    check("rst_flags", {28'b0, flags}, 32'h0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_in_ready", {31'b0, wb.in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
